// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor: one SEG-bit segment is resolved per stage,
// with a global stall for backpressure and registered carry/overflow/zero flags.
module pipelined_csel_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int SEG = WIDTH / STAGES;
    localparam logic [SEG:0] ONE = {{SEG{1'b0}}, 1'b1};

    // Per-stage state: operands stay full width, only segment k is consumed in stage k.
    logic             valid_q [STAGES];
    logic             carry_q [STAGES];
    logic [WIDTH-1:0] res_q   [STAGES];
    logic [WIDTH-1:0] opa_q   [STAGES];
    logic [WIDTH-1:0] opb_q   [STAGES];
    logic             amsb_q  [STAGES];
    logic             bmsb_q  [STAGES];

    logic [WIDTH-1:0] res_d   [STAGES];
    logic             carry_d [STAGES];

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             overflow_q;
    logic             zero_q;

    logic             stall;
    logic [WIDTH-1:0] bb_in;
    logic             c0_in;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;
    assign bb_in    = sub ? ~b : b;
    assign c0_in    = sub ? 1'b1 : cin;

    always_comb begin
        logic [SEG:0] lo;
        logic [SEG:0] hi;
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        lo = '0;
        hi = '0;
        for (int k = 0; k < STAGES; k++) begin
            lo = {1'b0, opa_q[k][k*SEG +: SEG]} + {1'b0, opb_q[k][k*SEG +: SEG]};
            hi = {1'b0, opa_q[k][k*SEG +: SEG]} + {1'b0, opb_q[k][k*SEG +: SEG]} + ONE;
            res_d[k]                 = res_q[k];
            res_d[k][k*SEG +: SEG]   = carry_q[k] ? hi[SEG-1:0] : lo[SEG-1:0];
            carry_d[k]               = carry_q[k] ? hi[SEG] : lo[SEG];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: these are pipeline registers, not a memory, so every one is cleared.
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                res_q[k]   <= '0;
                opa_q[k]   <= '0;
                opb_q[k]   <= '0;
                amsb_q[k]  <= 1'b0;
                bmsb_q[k]  <= 1'b0;
            end
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else if (!stall) begin
            // NOTE: non-blocking so every stage samples its predecessor's old value.
            valid_q[0] <= in_valid;
            carry_q[0] <= c0_in;
            res_q[0]   <= '0;
            opa_q[0]   <= a;
            opb_q[0]   <= bb_in;
            amsb_q[0]  <= a[WIDTH-1];
            bmsb_q[0]  <= bb_in[WIDTH-1];
            for (int k = 1; k < STAGES; k++) begin
                valid_q[k] <= valid_q[k-1];
                carry_q[k] <= carry_d[k-1];
                res_q[k]   <= res_d[k-1];
                opa_q[k]   <= opa_q[k-1];
                opb_q[k]   <= opb_q[k-1];
                amsb_q[k]  <= amsb_q[k-1];
                bmsb_q[k]  <= bmsb_q[k-1];
            end
            // Last segment resolves straight into the output registers.
            out_valid_q <= valid_q[STAGES-1];
            sum_q       <= res_d[STAGES-1];
            cout_q      <= carry_d[STAGES-1];
            overflow_q  <= (amsb_q[STAGES-1] == bmsb_q[STAGES-1]) &&
                           (res_d[STAGES-1][WIDTH-1] != amsb_q[STAGES-1]);
            zero_q      <= (res_d[STAGES-1] == '0);
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Scoreboarded bench: directed cases on a 32/4 instance, random sweeps on 16/1 and 64/8.
`timescale 1ns/1ps
module tb_pipelined_csel_adder;
    localparam int NCFG   = 3;
    localparam int NSWEEP = 10000;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        longint      tag;
    } exp_t;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic sweep_go = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain (a + bb + c0) mod 2^w arithmetic on wide integers.
    function automatic exp_t model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                   input logic c, input logic s, input longint tag);
        exp_t        e;
        logic [63:0] mask;
        logic [63:0] am;
        logic [63:0] bb;
        logic [64:0] full;
        mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        am     = av & mask;
        bb     = (s ? ~bv : bv) & mask;
        full   = {1'b0, am} + {1'b0, bb} + {64'd0, (s ? 1'b1 : c)};
        e.sum  = full[63:0] & mask;
        e.cout = full[w];
        e.ovf  = (am[w-1] == bb[w-1]) && (e.sum[w-1] != am[w-1]);
        e.zero = (e.sum == 64'd0);
        e.tag  = tag;
        return e;
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int W = (g == 0) ? 32 : (g == 1) ? 16 : 64;
        localparam int S = (g == 0) ? 4 : (g == 1) ? 1 : 8;

        logic         in_valid  = 1'b0;
        logic         out_ready = 1'b1;
        logic         cin       = 1'b0;
        logic         sub       = 1'b0;
        logic [W-1:0] a         = '0;
        logic [W-1:0] b         = '0;
        logic         in_ready;
        logic         out_valid;
        logic         cout;
        logic         overflow;
        logic         zero;
        logic [W-1:0] sum;
        logic         done      = 1'b0;
        logic         send_done = 1'b0;
        exp_t         q[$];
        exp_t         e_m;
        logic         stall_m;
        longint       adv   = 0;
        int           n_out = 0;
        int           wcnt  = 0;

        pipelined_csel_adder #(.WIDTH(W), .STAGES(S)) dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .a        (a),
            .b        (b),
            .cin      (cin),
            .sub      (sub),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .sum      (sum),
            .cout     (cout),
            .overflow (overflow),
            .zero     (zero)
        );

        // Monitor: adv counts pipeline advances; a beat needs S of them plus its transfer edge.
        always @(negedge clk) begin
            if (rst) begin
                q.delete();
            end else begin
                stall_m = out_valid && !out_ready;
                check($sformatf("cfg%0d in_ready", g), 64'(in_ready), 64'(!stall_m));
                if (!stall_m) adv++;
                if (in_valid && !stall_m)
                    q.push_back(model(W, 64'(a), 64'(b), cin, sub, adv));
                if (out_valid && out_ready) begin
                    n_out++;
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL cfg%0d spurious result: got sum 0x%0h, expected no result", g, sum);
                    end else begin
                        e_m = q.pop_front();
                        check($sformatf("cfg%0d sum", g),      64'(sum),      e_m.sum);
                        check($sformatf("cfg%0d cout", g),     64'(cout),     64'(e_m.cout));
                        check($sformatf("cfg%0d overflow", g), 64'(overflow), 64'(e_m.ovf));
                        check($sformatf("cfg%0d zero", g),     64'(zero),     64'(e_m.zero));
                        check($sformatf("cfg%0d latency", g),  64'(adv - e_m.tag), 64'(S + 1));
                    end
                end
            end
        end

        if (g != 0) begin : sw
            initial begin
                wait (sweep_go);
                @(posedge clk);
                #1;
                fork
                    begin
                        for (int n = 0; n < NSWEEP; n++) begin
                            a   = W'({$urandom(), $urandom()});
                            b   = W'({$urandom(), $urandom()});
                            cin = 1'($urandom_range(0, 1));
                            sub = 1'($urandom_range(0, 1));
                            if ($urandom_range(0, 7) == 0) a = '1;
                            if ($urandom_range(0, 7) == 0) b = a;
                            in_valid = 1'b1;
                            wcnt = 0;
                            do begin
                                @(negedge clk);
                                wcnt++;
                            end while (!in_ready && wcnt < 100);
                            if (!in_ready) begin
                                checks++;
                                errors++;
                                $display("FAIL cfg%0d accept timeout: in_ready=0, expected 1", g);
                            end
                            @(posedge clk);
                            #1;
                            in_valid = 1'b0;
                            if ($urandom_range(0, 3) == 0) begin
                                @(posedge clk);
                                #1;
                            end
                        end
                        send_done = 1'b1;
                    end
                    begin
                        while (!send_done) begin
                            out_ready = ($urandom_range(0, 3) != 0);
                            @(posedge clk);
                            #1;
                        end
                    end
                join
                out_ready = 1'b1;
                wcnt = 0;
                while (q.size() != 0 && wcnt < 200) begin
                    @(negedge clk);
                    wcnt++;
                end
                check($sformatf("cfg%0d drain", g), 64'(q.size()), 64'd0);
                repeat (2) @(posedge clk);
                done = 1'b1;
            end
        end
    end

    task automatic send0(input logic [31:0] av, input logic [31:0] bv, input logic c, input logic s);
        int n;
        cfg[0].a        = av;
        cfg[0].b        = bv;
        cfg[0].cin      = c;
        cfg[0].sub      = s;
        cfg[0].in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cfg[0].in_ready && n < 50);
        if (!cfg[0].in_ready) begin
            checks++;
            errors++;
            $display("FAIL send0 timeout: in_ready=0, expected 1");
        end
        @(posedge clk);
        #1;
        cfg[0].in_valid = 1'b0;
    endtask

    // Single beat into an idle pipeline: out_valid must rise exactly 4 edges after accept.
    task automatic directed(input string name, input logic [31:0] av, input logic [31:0] bv,
                            input logic c, input logic s, input logic [31:0] es,
                            input logic ec, input logic eo, input logic ez);
        send0(av, bv, c, s);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check({name, " early valid"}, 64'(cfg[0].out_valid), 64'd0);
        end
        @(negedge clk);
        check({name, " valid"},    64'(cfg[0].out_valid), 64'd1);
        check({name, " sum"},      64'(cfg[0].sum),       64'(es));
        check({name, " cout"},     64'(cfg[0].cout),      64'(ec));
        check({name, " overflow"}, 64'(cfg[0].overflow),  64'(eo));
        check({name, " zero"},     64'(cfg[0].zero),      64'(ez));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 64'(cfg[0].out_valid), 64'd0);
        check("reset sum",       64'(cfg[0].sum),       64'd0);
        check("reset zero",      64'(cfg[0].zero),      64'd0);
        check("reset in_ready",  64'(cfg[0].in_ready),  64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        directed("add",      32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
        directed("carry",    32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
        directed("ovf add",  32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        directed("sub",      32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        directed("ovf sub",  32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);

        // Streaming: out_ready drops for four edges while beats keep arriving.
        base = cfg[0].n_out;
        fork
            begin
                for (int i = 0; i < 8; i++) send0(32'(i), 32'(i * 16), 1'b0, 1'b0);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                cfg[0].out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("stall in_ready", 64'(cfg[0].in_ready),  64'd0);
                    check("stall valid",    64'(cfg[0].out_valid), 64'd1);
                    check("stall held sum", 64'(cfg[0].sum),       64'd17);
                end
                @(posedge clk);
                #1;
                cfg[0].out_ready = 1'b1;
            end
        join
        for (int i = 0; i < 50 && cfg[0].n_out < base + 8; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        check("stream count", 64'(cfg[0].n_out - base), 64'd8);

        // Reset with three beats in flight, none of them at the output yet.
        send0(32'h11111111, 32'h1, 1'b0, 1'b0);
        send0(32'h22222222, 32'h2, 1'b0, 1'b0);
        send0(32'h33333333, 32'h3, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst out_valid", 64'(cfg[0].out_valid), 64'd0);
        check("midrst sum",       64'(cfg[0].sum),       64'd0);
        check("midrst cout",      64'(cfg[0].cout),      64'd0);
        check("midrst overflow",  64'(cfg[0].overflow),  64'd0);
        check("midrst zero",      64'(cfg[0].zero),      64'd0);
        check("midrst in_ready",  64'(cfg[0].in_ready),  64'd1);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        base = cfg[0].n_out;
        repeat (6) begin
            @(negedge clk);
            check("post-reset valid", 64'(cfg[0].out_valid), 64'd0);
        end
        check("post-reset count", 64'(cfg[0].n_out - base), 64'd0);
        @(posedge clk);
        #1;
        directed("after rst", 32'h00001234, 32'h00004321, 1'b1, 1'b0, 32'h00005556, 1'b0, 1'b0, 1'b0);

        sweep_go = 1'b1;
        for (int i = 0; i < 60000 && !(cfg[1].done && cfg[2].done); i++) @(posedge clk);
        check("sweep complete", 64'(cfg[1].done && cfg[2].done), 64'd1);
        check("sweep16 results", 64'(cfg[1].n_out), 64'(NSWEEP));
        check("sweep64 results", 64'(cfg[2].n_out), 64'(NSWEEP));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_csel_adder.md
Name: pipelined_csel_adder

Overview:
Parametrised, pipelined carry-select adder/subtractor for the datapath's wide arithmetic. Operands split into STAGES equal segments. Each segment computes two candidate sums (carry-in 0 and 1) and selects one with the registered carry from the previous segment, one segment per pipeline stage. Provides a valid/ready handshake on input and output, full backpressure, an add/sub mode, and carry, signed-overflow and zero flags.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of STAGES
STAGES, 4, pipeline depth and number of carry-select segments; SEG = WIDTH/STAGES bits per segment; legal 1..WIDTH

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high; clears all state
in_valid  in  1  operand beat offered
in_ready  out  1  block can accept a beat this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in; used only when sub=0
sub  in  1  0: a+b+cin; 1: a-b (cin ignored)
out_valid  out  1  result beat available
out_ready  in  1  downstream accepts result
sum  out  WIDTH  result
cout  out  1  carry-out of MSB (for sub: 1 = no borrow)
overflow  out  1  signed two's-complement overflow
zero  out  1  sum == 0

Behaviour:
- Effective operands: bb = sub ? ~b : b; c0 = sub ? 1 : cin. The result always equals (a + bb + c0) mod 2^WIDTH. cout = bit WIDTH of that sum.
- overflow = (a[MSB] == bb[MSB]) && (sum[MSB] != a[MSB]).
- zero = (sum == 0), computed from the final registered sum.
- Accept: a beat is taken on a rising edge with in_valid && in_ready.
- Transfer: a result is consumed on a rising edge with out_valid && out_ready.
- Stage k (0..STAGES-1) holds:
  - a valid bit;
  - the registered carry into segment k;
  - the sum bits already resolved for segments 0..k-1;
  - the upper operand bits still pending;
  - a[MSB] and bb[MSB] for the overflow calculation.
- In stage k, segment k computes s0/c0 (carry-in 0) and s1/c1 (carry-in 1) in parallel. It selects on the registered carry and passes the result to stage k+1. No ripple crosses a stage boundary.
- Latency: a beat accepted at edge T has out_valid=1 after edge T+STAGES, given no stall. Throughput is one beat per cycle.
- Backpressure: stall = out_valid && !out_ready. in_ready = !stall, which is combinational from out_valid/out_ready.
  - While stalled, every stage register holds its contents.
  - Bubbles (valid=0) are not compressed. This global stall is the chosen, simple behaviour.
- Output registers: sum, cout, overflow and zero are registered and stay stable while out_valid && !out_ready.
- When no beat is accepted in a non-stalled cycle, a bubble (valid=0) enters stage 0.
- Reset, asynchronous at any time including mid-operation:
  - all valid bits cleared; sum=0, cout=0, overflow=0, zero=0, out_valid=0;
  - in-flight beats are discarded;
  - in_ready=1 during and after reset.
- STAGES=1 degenerates to a single carry-select segment with one register stage (latency 1).
- Data/flag outputs while out_valid=0 are don't-care apart from their reset values.
- Simultaneous accept and output transfer in the same cycle is legal and required for full throughput.

Test Plan:
- Basic add (WIDTH=32, STAGES=4): a=0x0000FFFF, b=0x00000001, cin=0, sub=0 -> exactly 4 cycles later out_valid=1, sum=0x00010000, cout=0, overflow=0, zero=0.
- Cross-segment carry and flags: a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, zero=1, overflow=0. Separately, a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, overflow=1, cout=0.
- Subtract: sub=1, a=5, b=7, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, overflow=0. Separately, sub=1, a=0x80000000, b=1 -> sum=0x7FFFFFFF, overflow=1, cout=1.
- Streaming with backpressure: 8 back-to-back beats a=i, b=i*16, with out_ready low for cycles 6..9.
  - During the stall: in_ready=0 and the output is held stable.
  - Afterwards: all 8 results appear in order, none lost or duplicated, and sum=17*i.
- Reset mid-flight: accept 3 beats, assert rst for one cycle before any output -> out_valid=0 and all outputs 0 immediately. No stale result appears afterwards; the next beat returns after 4 cycles.
- Parameter sweep (WIDTH=16/STAGES=1, WIDTH=64/STAGES=8): 10k random a, b, cin, sub with random out_ready -> every result matches the reference a+bb+c0 model, and latency equals STAGES when unstalled.
